// File: rtl/cache_refill_if.sv
// CPU / cache-array / memory bundle for the refill controller.
// master = controller side, slave = environment side.
interface cache_refill_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [DATA_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;

  logic                  cache_hit;
  logic [DATA_WIDTH-1:0] cache_dout;
  logic [DATA_WIDTH-1:0] cache_addr;
  logic                  cache_wen;
  logic [DATA_WIDTH-1:0] cache_din;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cache_hit, cache_dout,
    input  mem_rdata, mem_ack,
    output cpu_rdata, cpu_stall,
    output cache_addr, cache_wen, cache_din,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cache_hit, cache_dout,
    output mem_rdata, mem_ack,
    input  cpu_rdata, cpu_stall,
    input  cache_addr, cache_wen, cache_din,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Read-miss refill / write-through controller for a direct-mapped cache.
// Define CACHE_STATS_EN to add saturating hit/miss counters.
module cache_refill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_refill_if.master        bus
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_hits,
  output logic [STAT_WIDTH-1:0] stat_misses
`endif
);

  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FILL,
    WRITE
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   fill_q;
  logic            mem_req_q;
  logic            mem_we_q;

  logic            rd_hit;
  logic            rd_miss;
  logic            is_idle;

  assign is_idle = (state_q == IDLE);
  assign rd_hit  = bus.cpu_rd & ~bus.cpu_wr & bus.cache_hit;
  assign rd_miss = bus.cpu_rd & ~bus.cpu_wr & ~bus.cache_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      fill_q    <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            bus.cpu_wr: begin
              addr_q    <= bus.cpu_addr;
              wdata_q   <= bus.cpu_wdata;
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b1;
              state_q   <= WRITE;
            end
            rd_miss: begin
              addr_q    <= bus.cpu_addr;
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
              state_q   <= FETCH;
            end
            default: ;
          endcase
        end
        FETCH: begin
          if (bus.mem_ack) begin
            fill_q    <= bus.mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= FILL;
          end
        end
        FILL: begin
          state_q <= IDLE;
        end
        WRITE: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // memory side is held in flops so it stays stable for the whole request
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  always_comb begin
    bus.cpu_stall  = 1'b0;
    bus.cpu_rdata  = '0;
    bus.cache_addr = addr_q;
    bus.cache_wen  = 1'b0;
    bus.cache_din  = '0;
    unique case (state_q)
      IDLE: begin
        bus.cache_addr = bus.cpu_addr;
        bus.cpu_stall  = bus.cpu_wr | rd_miss;
        if (rd_hit) begin
          bus.cpu_rdata = bus.cache_dout;
        end
      end
      FETCH: begin
        bus.cpu_stall = 1'b1;
      end
      FILL: begin
        bus.cache_wen = 1'b1;
        bus.cache_din = fill_q;
        bus.cpu_rdata = fill_q;
      end
      WRITE: begin
        bus.cpu_stall = ~bus.mem_ack;
        bus.cache_wen = bus.mem_ack;
        bus.cache_din = wdata_q;
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  localparam logic [STAT_WIDTH-1:0] SONE = 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (is_idle && rd_hit && stat_hits != '1) begin
        stat_hits <= stat_hits + SONE;
      end
      if (is_idle && rd_miss && stat_misses != '1) begin
        stat_misses <= stat_misses + SONE;
      end
    end
  end
`endif

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-handling controller that sits between the CPU load/store port, the direct-mapped single-word-line cache array and the backing data memory. It drives the cache's write side:
- On a read miss it fetches the word from memory, fills the line and returns the data.
- On a store it writes through to memory and updates the cache line (write-allocate).

Read hits complete with zero added latency; every other access stalls the CPU until done.

## Interface
Parameters:
- DATA_WIDTH, 32, address/data width
- STAT_WIDTH, 16, width of each statistics counter (only with CACHE_STATS_EN)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cpu_rd  in  1  load request, held until cpu_stall low
- cpu_wr  in  1  store request, held until cpu_stall low; wins if cpu_rd also high
- cpu_addr  in  DATA_WIDTH  byte address, word aligned
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_rdata  out  DATA_WIDTH  load data, valid when cpu_rd & !cpu_stall
- cpu_stall  out  1  CPU must hold request
- cache_hit  in  1  hit flag from cache for cache_addr
- cache_dout  in  DATA_WIDTH  cached word for cache_addr
- cache_addr  out  DATA_WIDTH  address presented to cache
- cache_wen  out  1  cache line write strobe (sets valid, tag, data)
- cache_din  out  DATA_WIDTH  data written into cache
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; stable while mem_req
- mem_addr  out  DATA_WIDTH  memory address, stable while mem_req
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse

## Operation
States: IDLE, FETCH, FILL, WRITE.

IDLE:
- cache_addr = cpu_addr.
- Read hit (cpu_rd & !cpu_wr & cache_hit): cpu_rdata = cache_dout, cpu_stall = 0, state stays IDLE.
- Read miss: cpu_stall = 1; latch cpu_addr into addr_q; go to FETCH.
- Store: cpu_stall = 1; latch addr_q and wdata_q; go to WRITE.

FETCH:
- mem_req = 1, mem_we = 0, mem_addr = addr_q, cpu_stall = 1.
- On mem_ack, capture mem_rdata into fill_q and go to FILL.

FILL:
- cache_wen = 1, cache_addr = addr_q, cache_din = fill_q.
- cpu_rdata = fill_q, cpu_stall = 0; go to IDLE.

WRITE:
- mem_req = 1, mem_we = 1, mem_addr = addr_q, mem_wdata = wdata_q, cpu_stall = 1.
- On mem_ack: cache_wen = 1, cache_addr = addr_q, cache_din = wdata_q, cpu_stall = 0; go to IDLE.

General rules:
- cache_addr = addr_q in every non-IDLE state.
- mem_req never drops before mem_ack.
- mem_ack outside FETCH/WRITE is ignored.
- Neither cpu_rd nor cpu_wr: all strobes 0, stay IDLE.

## Timing
- Reset (async assert, sync release) forces IDLE. Reset values:
  - mem_req = 0, mem_we = 0, cache_wen = 0.
  - addr_q, wdata_q and fill_q cleared to 0.
  - cpu_stall = 0; cpu_rdata, mem_addr, mem_wdata, cache_din = 0.
  - Counters = 0.
- Reset mid-transaction: mem_req drops immediately and the in-flight access is abandoned; a later mem_ack is ignored.
- Read hit: 0 extra cycles.
- Read miss, with N = cycles from the first mem_req cycle to mem_ack inclusive (N ≥ 1): cpu_stall high for 1 + N cycles, low in the FILL cycle. Data is in the cache from the next cycle.
- Store: stall high for 1 + N − 1 cycles, low in the ack cycle; the cache write lands at the end of the ack cycle.
- A back-to-back access is accepted in the IDLE cycle after FILL/ack.

## Configuration
- CACHE_STATS_EN defined:
  - Adds outputs stat_hits and stat_misses, STAT_WIDTH each.
  - stat_hits increments on each completed read hit; stat_misses on each FETCH entry.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Read hit: cache_hit = 1, cache_dout = 0xCAFEF00D, cpu_rd at 0x40 → same cycle cpu_stall = 0, cpu_rdata = 0xCAFEF00D, no mem_req.
- Read miss: cpu_rd 0x104, mem_ack after 3 req cycles with 0x12345678 → stall 4 cycles; FILL cycle has cache_wen = 1, cache_din = 0x12345678, cpu_rdata = 0x12345678.
- Store 0xDEADBEEF to 0x80, ack after 2 cycles → mem_we = 1 and mem_addr = 0x80 held both cycles; in the ack cycle cache_wen = 1, stall = 0.
- cpu_rd and cpu_wr both high → store path taken, no FETCH.
- rst_n low during FETCH → mem_req = 0 immediately, state IDLE. A mem_ack pulse after release → no cache_wen.
- CACHE_STATS_EN: 2 hits, 1 miss → stat_hits = 2, stat_misses = 1. Preload counters at all-ones → no wrap.
